// File: rtl/tick_generator_pkg.sv
// rtl/tick_generator_pkg.sv - shared types and width helpers for the tick generator
package tick_pkg;

    // Channel operating mode; the encoding is the value software writes on mode_data.
    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_t;

    // Default build sizes for the generator.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCH   = 4;
    localparam int DEF_DIVW  = 26;

    // A channel-select bus is never narrower than one bit, even for a single channel.
    function automatic int sel_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/tick_generator_channel.sv
// rtl/tick_generator_channel.sv - one programmable tick channel (divisor, down-counter, mode)
module tick_channel
    import tick_pkg::*;
#(
    parameter int              DIVW    = 26,
    parameter logic [DIVW-1:0] DEF_DIV = {DIVW{1'b1}}
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_en,
    input  logic            i_div_wr,
    input  logic            i_mode_wr,
    input  logic [DIVW-1:0] i_div_data,
    input  mode_t           i_mode_data,
    input  logic            i_start,
    output logic            o_tick,
    output logic            o_busy
);

    logic [DIVW-1:0] r_div;
    logic [DIVW-1:0] r_cnt;
    mode_t           r_mode;
    logic            r_tick;
    logic            r_busy;

    logic [DIVW-1:0] w_div_nxt;
    logic [DIVW-1:0] w_cnt_nxt;
    mode_t           w_mode_nxt;
    logic            w_tick_nxt;
    logic            w_busy_nxt;
    logic            w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // Next-state: a mode write dominates, then periodic counting or one-shot start/run/idle.
    // Reloads use the divisor as registered at this edge, so a divisor write only shapes
    // the period after the one already in flight.
    always_comb begin
        w_div_nxt  = i_div_wr ? i_div_data : r_div;
        w_mode_nxt = r_mode;
        w_cnt_nxt  = r_cnt;
        w_tick_nxt = 1'b0;
        w_busy_nxt = r_busy;

        if (i_mode_wr) begin
            w_mode_nxt = i_mode_data;
            w_cnt_nxt  = w_div_nxt;
            w_busy_nxt = (i_mode_data == MODE_PERIODIC);
        end else if (r_mode == MODE_PERIODIC) begin
            w_busy_nxt = 1'b1;
            if (i_en) begin
                if (w_cnt_zero) begin
                    w_tick_nxt = 1'b1;
                    w_cnt_nxt  = r_div;
                end else begin
                    w_cnt_nxt = r_cnt - DIVW'(1);
                end
            end
        end else if (i_start) begin
            // Start (or retrigger) wins even on the terminal edge, suppressing that tick.
            w_cnt_nxt  = r_div;
            w_busy_nxt = 1'b1;
        end else if (r_busy) begin
            if (i_en) begin
                if (w_cnt_zero) begin
                    w_tick_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                    w_cnt_nxt  = r_div;
                end else begin
                    w_cnt_nxt = r_cnt - DIVW'(1);
                end
            end
        end else begin
            // Idle one-shot keeps the counter parked on the divisor.
            w_cnt_nxt = r_div;
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_div  <= DEF_DIV;
            r_cnt  <= DEF_DIV;
            r_mode <= MODE_PERIODIC;
            r_tick <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_cnt  <= w_cnt_nxt;
            r_mode <= w_mode_nxt;
            r_tick <= w_tick_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign o_tick = r_tick;
    assign o_busy = r_busy;

endmodule

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - free-running cycle counter plus NCH programmable tick channels
module tick_generator
    import tick_pkg::*;
#(
    parameter int              WIDTH   = DEF_WIDTH,
    parameter int              NCH     = DEF_NCH,
    parameter int              DIVW    = DEF_DIVW,
    parameter logic [DIVW-1:0] DEF_DIV = {DIVW{1'b1}},
    localparam int             SELW    = sel_w(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_wr,
    input  logic             mode_wr,
    input  logic [SELW-1:0]  wr_sel,
    input  logic [DIVW-1:0]  div_data,
    input  logic             mode_data,
    input  logic [NCH-1:0]   start,
    output logic [WIDTH-1:0] count,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy
);

    logic [WIDTH-1:0] r_count;
    logic [NCH-1:0]   w_tick;
    logic [NCH-1:0]   w_busy;

    // Free-running counter: advances on enabled edges and wraps naturally at full scale.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Write decode: an out-of-range wr_sel matches no channel, so the write is dropped.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic w_sel_hit;
        assign w_sel_hit = (wr_sel == SELW'(gi));

        tick_channel #(
            .DIVW    (DIVW),
            .DEF_DIV (DEF_DIV)
        ) u_channel (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_en        (en),
            .i_div_wr    (div_wr && w_sel_hit),
            .i_mode_wr   (mode_wr && w_sel_hit),
            .i_div_data  (div_data),
            .i_mode_data (mode_t'(mode_data)),
            .i_start     (start[gi]),
            .o_tick      (w_tick[gi]),
            .o_busy      (w_busy[gi])
        );
    end

    assign count = r_count;
    assign tick  = w_tick;
    assign busy  = w_busy;

endmodule
